// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, one registered bit per clk out.
// Optional even-parity trailer bit when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_data,
  output logic             ser_en,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3} state_t;
`endif

  // With no gap the FSM returns straight to IDLE while the final bit is still on the wire.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic             par_bit;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] sr);
    return MSB_FIRST ? sr[WIDTH-1] : sr[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] sr);
    return MSB_FIRST ? (sr << 1) : (sr >> 1);
  endfunction

  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Frame sequencer; all serial outputs are registered here.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= 4'd0;
      ser_data <= 1'b0;
      ser_en   <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ser_en   <= 1'b0;
          ser_data <= 1'b0;
          done     <= 1'b0;
          if (din_valid) begin
            shreg   <= din;
            bit_cnt <= '0;
            state   <= SHIFT;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_bit <= even_parity(din);
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          ser_en   <= 1'b1;
          ser_data <= head_bit(shreg);
          shreg    <= advance(shreg);
          if (bit_cnt == LAST_BIT) begin
            gap_cnt <= 4'd0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            done    <= 1'b0;
            state   <= PAR;
`else
            done    <= 1'b1;
            state   <= AFTER_FRAME;
`endif
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            done    <= 1'b0;
          end
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        PAR: begin
          ser_en   <= 1'b1;
          ser_data <= par_bit;
          done     <= 1'b1;
          gap_cnt  <= 4'd0;
          state    <= AFTER_FRAME;
        end
`endif
        GAP: begin
          ser_en   <= 1'b0;
          ser_data <= 1'b0;
          done     <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          ser_en   <= 1'b0;
          ser_data <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: three instances (MSB/GAP1, LSB/GAP1, MSB/GAP0).
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] din       [3];
  logic       din_valid [3];
  logic       din_ready [3];
  logic       ser_data  [3];
  logic       ser_en    [3];
  logic       done      [3];
  logic       busy      [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u_msb (
    .clk(clk), .clr(clr), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .ser_data(ser_data[0]), .ser_en(ser_en[0]), .done(done[0]), .busy(busy[0]));

  serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u_lsb (
    .clk(clk), .clr(clr), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .ser_data(ser_data[1]), .ser_en(ser_en[1]), .done(done[1]), .busy(busy[1]));

  serial_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .clr(clr), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .ser_data(ser_data[2]), .ser_en(ser_en[2]), .done(done[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected bit b of a frame: data bits in wire order, then the even-parity bit.
  function automatic logic exp_bit(input int idx, input logic [7:0] w, input int b);
    if (b == 8) return ^w;
    return (idx == 1) ? w[b] : w[7-b];
  endfunction

  task automatic frame(input int idx, input logic [7:0] w, input bit noise);
    din[idx] = w;
    din_valid[idx] = 1'b1;
    @(posedge clk); #1;
    check("load_en", ser_en[idx], 1'b0);
    check("load_rdy", din_ready[idx], 1'b0);
    din_valid[idx] = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (noise) begin
        din[idx] = ~din[idx];
        din_valid[idx] = ~din_valid[idx];
      end
      @(posedge clk); #1;
      check("bit_en", ser_en[idx], 1'b1);
      check("bit_data", ser_data[idx], exp_bit(idx, w, b));
      check("bit_done", done[idx], (b == NB - 1) ? 1'b1 : 1'b0);
      if (noise) check("shift_rdy", din_ready[idx], 1'b0);
    end
    din_valid[idx] = 1'b0;
    check("last_rdy", din_ready[idx], (idx == 2) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    check("post_en", ser_en[idx], 1'b0);
    check("post_data", ser_data[idx], 1'b0);
    check("post_done", done[idx], 1'b0);
    check("post_rdy", din_ready[idx], 1'b1);
  endtask

  task automatic b2b(input int idx, input logic [7:0] w1, input logic [7:0] w2, input int exp_dead);
    int  dead;
    bit  found;
    din[idx] = w1;
    din_valid[idx] = 1'b1;
    @(posedge clk); #1;
    din[idx] = w2;
    for (int b = 0; b < NB; b++) begin
      @(posedge clk); #1;
      check("b2b1_data", ser_data[idx], exp_bit(idx, w1, b));
    end
    dead = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ser_en[idx]) begin
        found = 1'b1;
        break;
      end
      dead++;
    end
    din_valid[idx] = 1'b0;
    check("b2b_found", found, 1'b1);
    check("b2b_dead", dead, exp_dead);
    check("b2b2_data0", ser_data[idx], exp_bit(idx, w2, 0));
    for (int b = 1; b < NB; b++) begin
      @(posedge clk); #1;
      check("b2b2_data", ser_data[idx], exp_bit(idx, w2, b));
      check("b2b2_done", done[idx], (b == NB - 1) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    check("b2b_tail_en", ser_en[idx], 1'b0);
  endtask

  initial begin
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00;
      din_valid[i] = 1'b0;
    end
    // Reset held for 30 ns
    for (int t = 0; t < 3; t++) begin
      #5;
      check("rst_en", ser_en[0], 1'b0);
      check("rst_data", ser_data[0], 1'b0);
      check("rst_done", done[0], 1'b0);
      check("rst_rdy", din_ready[0], 1'b1);
      check("rst_busy", busy[0], 1'b0);
      #5;
    end
    @(posedge clk); #1;
    clr = 1'b0;

    frame(0, 8'hA5, 1'b0);
    frame(1, 8'hA5, 1'b0);
    frame(1, 8'h01, 1'b0);
    b2b(0, 8'hF0, 8'h0F, 2);
    b2b(2, 8'hF0, 8'h0F, 1);

    // Abort mid-frame after the third bit
    din[0] = 8'hFF;
    din_valid[0] = 1'b1;
    @(posedge clk); #1;
    din_valid[0] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      check("abort_pre_en", ser_en[0], 1'b1);
    end
    #4 clr = 1'b1;
    #1;
    check("abort_en", ser_en[0], 1'b0);
    check("abort_data", ser_data[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_rdy", din_ready[0], 1'b1);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", done[0], 1'b0);
      check("abort_noen", ser_en[0], 1'b0);
    end
    frame(0, 8'h3C, 1'b0);

    frame(0, 8'h5A, 1'b1);
    frame(1, 8'hC3, 1'b1);
    frame(0, 8'h07, 1'b0);
    frame(2, 8'hA5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
